// File: rtl/aib_pkg.sv
// Shared AIB definitions: lane width, scheduler state encoding and idle word.
package aib_pkg;

   localparam int AIB_DATA_W = 80;

   // Scheduler FSM: IDLE has no owner, GRANT holds the lane for one burst.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [AIB_DATA_W-1:0] AIB_IDLE_WORD = '0;

endpackage

// File: rtl/aib_tx_scheduler_if.sv
// Requester-side and lane-side signals of the AIB transmit scheduler.
//
// Handshake: a beat on requester i transfers in a cycle where
// req_valid[i] and req_ready[i] are both high. req_ready is at most one-hot
// and never depends on req_valid. req_last is meaningful only with
// req_valid. A source may withdraw req_valid without losing the grant.
interface aib_tx_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 80,
   parameter int OWN_W   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         txdata;
   logic                      tx_valid;
   logic [OWN_W-1:0]          tx_owner;
   logic                      tx_active;

   // Traffic sources plus the lane consumer.
   modport master (
      output req_valid, req_last, req_data,
      input  req_ready, txdata, tx_valid, tx_owner, tx_active
   );

   // The scheduler.
   modport slave (
      input  req_valid, req_last, req_data,
      output req_ready, txdata, tx_valid, tx_owner, tx_active
   );
endinterface

// File: rtl/aib_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past last_granted
// and wraps, so the most recent winner has the lowest priority.
module aib_rr_arbiter #(
   parameter int  NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_granted,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // Walk the requesters in rotated order and keep the first one asking.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last_granted) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/aib_tx_scheduler.sv
// Shares the AIB transmit lane among NUM_REQ requesters, one burst per grant.
// A burst ends on LAST, on MAX_BURST beats, or when the link drops; the lane
// carries IDLE_WORD whenever no beat is issued.
module aib_tx_scheduler
   import aib_pkg::*;
#(
   parameter int               NUM_REQ   = 4,
   parameter int               DATA_W    = AIB_DATA_W,
   parameter int               MAX_BURST = 8,
   parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(AIB_IDLE_WORD)
) (
   input  logic                txclk,
   input  logic                rst_n,
   input  logic                link_up,
   aib_tx_scheduler_if.slave   bus,
   output state_t              dbg_state
);

   localparam int OWN_W = $clog2(NUM_REQ);

   state_t              state_q, state_d;
   logic [OWN_W-1:0]    owner_q, owner_d;
   logic [OWN_W-1:0]    last_q, last_d;
   logic [7:0]          count_q, count_d;
   logic [DATA_W-1:0]   txdata_q;
   logic                tx_valid_q;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [OWN_W-1:0]    arb_idx;
   logic                accept;

   aib_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req          (bus.req_valid),
      .last_granted (last_q),
      .grant        (arb_grant),
      .grant_idx    (arb_idx)
   );

   // A beat moves only while the grant is held and the link is up.
   assign accept = (state_q == GRANT) && link_up && bus.req_valid[owner_q];

   // Ready comes from registered state and link_up only, so no path from valid.
   always_comb begin
      bus.req_ready = '0;
      if (state_q == GRANT && link_up) begin
         bus.req_ready[owner_q] = 1'b1;
      end
   end

   // Next state: arbitrate in IDLE, count beats and find the burst end in GRANT.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (link_up && |arb_grant) begin
               state_d = GRANT;
               owner_d = arb_idx;
               last_d  = arb_idx;
               count_d = '0;
            end
         end
         GRANT: begin
            if (!link_up) begin
               state_d = IDLE;
            end else if (accept) begin
               count_d = count_q + 8'd1;
               if (bus.req_last[owner_q] || count_d == 8'(MAX_BURST)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, owner, round-robin pointer and beat counter.
   always_ff @(posedge txclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= OWN_W'(NUM_REQ - 1);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   // Lane register: the accepted beat, or the idle word.
   always_ff @(posedge txclk or negedge rst_n) begin
      if (!rst_n) begin
         txdata_q   <= IDLE_WORD;
         tx_valid_q <= 1'b0;
      end else if (accept) begin
         txdata_q   <= bus.req_data[owner_q*DATA_W +: DATA_W];
         tx_valid_q <= 1'b1;
      end else begin
         txdata_q   <= IDLE_WORD;
         tx_valid_q <= 1'b0;
      end
   end

   assign bus.txdata    = txdata_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_owner  = owner_q;
   assign bus.tx_active = (state_q == GRANT);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_aib_tx_scheduler.sv
// Bench for aib_tx_scheduler: directed scenarios then random traffic, with a
// transaction-level reference of the lane schedule and an expected-word queue.
module tb_aib_tx_scheduler;
   import aib_pkg::*;

   localparam int N  = 4;
   localparam int W  = 80;
   localparam int MB = 8;

   logic   txclk = 1'b0;
   logic   rst_n;
   logic   link_up;
   state_t dbg_state;

   aib_tx_scheduler_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

   aib_tx_scheduler #(
      .NUM_REQ   (N),
      .DATA_W    (W),
      .MAX_BURST (MB),
      .IDLE_WORD ('0)
   ) dut (
      .txclk     (txclk),
      .rst_n     (rst_n),
      .link_up   (link_up),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 txclk = ~txclk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- bench state ----------------
   int pass_cnt = 0;
   int fail_cnt = 0;
   int seq      = 0;

   logic [W-1:0] pq [N][$];   // pending beats per requester
   bit           lq [N][$];   // matching LAST flags
   bit           en [N];      // requester willing to present a beat
   bit           link_drv;

   // reference: who holds the lane, pointer, beats in this burst
   bit           m_active;
   int           m_owner;
   int           m_last;
   int           m_cnt;
   bit           m_txv;
   logic [W-1:0] exp_q [$];

   // what the DUT actually did, for the directed checks
   int dut_grants [$];
   int dut_bursts [$];
   int exp_grants [$];
   int exp_bursts [$];
   int obs_len;
   bit prev_active;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int r, input int n);
      for (int b = 0; b < n; b++) begin
         seq++;
         pq[r].push_back({8'(r), 24'(seq), 16'($urandom), 32'($urandom)});
         lq[r].push_back(b == n - 1);
      end
   endtask

   task automatic drive();
      logic [N-1:0]   v;
      logic [N-1:0]   l;
      logic [N*W-1:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
         if (pq[i].size() > 0 && en[i]) begin
            v[i]         = 1'b1;
            l[i]         = lq[i][0];
            d[i*W +: W]  = pq[i][0];
         end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      link_up       = link_drv;
   endtask

   task automatic model_reset();
      m_active    = 1'b0;
      m_owner     = 0;
      m_last      = N - 1;
      m_cnt       = 0;
      m_txv       = 1'b0;
      exp_q.delete();
      prev_active = 1'b0;
      obs_len     = 0;
   endtask

   task automatic clear_logs();
      dut_grants.delete();
      dut_bursts.delete();
      exp_grants.delete();
      exp_bursts.delete();
   endtask

   // Compare DUT outputs of the current cycle with the reference.
   task automatic check_outputs();
      logic [N-1:0] er;
      logic [W-1:0] ew;
      state_t       es;
      er = '0;
      if (m_active && link_drv) er[m_owner] = 1'b1;
      es = m_active ? GRANT : IDLE;
      ew = '0;
      if (m_txv && exp_q.size() > 0) ew = exp_q.pop_front();
      check("req_ready", W'(bus.req_ready), W'(er));
      check("tx_active", W'(bus.tx_active), W'(m_active));
      check("state", W'(dbg_state), W'(es));
      if (m_active) check("tx_owner", W'(bus.tx_owner), W'(m_owner));
      check("tx_valid", W'(bus.tx_valid), W'(m_txv));
      check("txdata", bus.txdata, ew);
      if (bus.tx_active && !prev_active) dut_grants.push_back(int'(bus.tx_owner));
      if (|(bus.req_valid & bus.req_ready)) obs_len++;
      if (!bus.tx_active && prev_active) begin
         dut_bursts.push_back(obs_len);
         obs_len = 0;
      end
      prev_active = bus.tx_active;
   endtask

   // Advance the reference by one cycle from the inputs the bench is driving.
   task automatic model_step();
      bit vreq [N];
      bit any;
      bit found;
      bit was_last;
      int c;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         vreq[i] = (pq[i].size() > 0) && en[i];
         any     = any | vreq[i];
      end
      m_txv = 1'b0;
      if (!m_active) begin
         if (link_drv && any) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!found && vreq[c]) begin
                  found   = 1'b1;
                  m_owner = c;
               end
            end
            m_last   = m_owner;
            m_active = 1'b1;
            m_cnt    = 0;
         end
      end else if (!link_drv) begin
         m_active = 1'b0;
      end else if (vreq[m_owner]) begin
         exp_q.push_back(pq[m_owner].pop_front());
         was_last = lq[m_owner].pop_front();
         m_cnt++;
         m_txv = 1'b1;
         if (was_last || m_cnt == MB) m_active = 1'b0;
      end
   endtask

   task automatic cycle();
      drive();
      @(negedge txclk);
      check_outputs();
      model_step();
      @(posedge txclk);
      #1;
   endtask

   function automatic bit busy();
      busy = m_active || m_txv;
      for (int i = 0; i < N; i++) if (pq[i].size() > 0) busy = 1'b1;
   endfunction

   task automatic run_until_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy() && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_drain"}, W'(busy()), W'(0));
      cycle();
      cycle();
   endtask

   task automatic compare_logs(input string tag);
      check({tag, "_grant_cnt"}, W'(dut_grants.size()), W'(exp_grants.size()));
      for (int k = 0; k < exp_grants.size() && k < dut_grants.size(); k++)
         check({tag, "_grant"}, W'(dut_grants[k]), W'(exp_grants[k]));
      check({tag, "_burst_cnt"}, W'(dut_bursts.size()), W'(exp_bursts.size()));
      for (int k = 0; k < exp_bursts.size() && k < dut_bursts.size(); k++)
         check({tag, "_burst_len"}, W'(dut_bursts[k]), W'(exp_bursts[k]));
      clear_logs();
   endtask

   task automatic wait_count(input string tag, input int target);
      int n;
      n = 0;
      while (!(m_active && m_cnt == target) && n < 50) begin
         cycle();
         n++;
      end
      check({tag, "_reach_beat"}, W'(n < 50), W'(1));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst_n    = 1'b0;
      link_drv = 1'b0;
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      drive();
      model_reset();
      clear_logs();

      // reset values
      @(negedge txclk);
      check("rst_txdata", bus.txdata, '0);
      check("rst_tx_valid", W'(bus.tx_valid), W'(0));
      check("rst_tx_active", W'(bus.tx_active), W'(0));
      check("rst_tx_owner", W'(bus.tx_owner), W'(0));
      check("rst_req_ready", W'(bus.req_ready), W'(0));
      check("rst_state", W'(dbg_state), W'(IDLE));
      @(posedge txclk);
      #1;
      rst_n    = 1'b1;
      link_drv = 1'b1;

      // all requesters with single-beat packets: 0,1,2,3,0
      push_pkt(0, 1); push_pkt(0, 1);
      push_pkt(1, 1); push_pkt(2, 1); push_pkt(3, 1);
      run_until_idle("rr", 100);
      exp_grants.push_back(0); exp_grants.push_back(1); exp_grants.push_back(2);
      exp_grants.push_back(3); exp_grants.push_back(0);
      for (int k = 0; k < 5; k++) exp_bursts.push_back(1);
      compare_logs("rr");

      // requesters 1 and 3 with 3-beat packets: 1,3,1
      push_pkt(1, 3); push_pkt(1, 3); push_pkt(3, 3);
      run_until_idle("pair", 100);
      exp_grants.push_back(1); exp_grants.push_back(3); exp_grants.push_back(1);
      for (int k = 0; k < 3; k++) exp_bursts.push_back(3);
      compare_logs("pair");

      // requester 2 streams 20 beats: cut into 8, 8, 4
      push_pkt(2, 20);
      run_until_idle("cut", 200);
      for (int k = 0; k < 3; k++) exp_grants.push_back(2);
      exp_bursts.push_back(8); exp_bursts.push_back(8); exp_bursts.push_back(4);
      compare_logs("cut");

      // link drops on beat 2 of a 5-beat burst
      push_pkt(0, 5);
      wait_count("link", 1);
      link_drv = 1'b0;
      cycle();
      link_drv = 1'b1;
      run_until_idle("link", 100);
      exp_grants.push_back(0); exp_grants.push_back(0);
      exp_bursts.push_back(1); exp_bursts.push_back(4);
      compare_logs("link");

      // owner withdraws valid for 3 cycles mid-burst
      push_pkt(3, 6);
      wait_count("gap", 2);
      en[3] = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
      en[3] = 1'b1;
      run_until_idle("gap", 100);
      exp_grants.push_back(3);
      exp_bursts.push_back(6);
      compare_logs("gap");

      // reset pulse mid-burst
      push_pkt(1, 5);
      wait_count("rst", 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_txdata", bus.txdata, '0);
      check("midrst_tx_valid", W'(bus.tx_valid), W'(0));
      check("midrst_tx_active", W'(bus.tx_active), W'(0));
      check("midrst_req_ready", W'(bus.req_ready), W'(0));
      model_reset();
      clear_logs();
      @(posedge txclk);
      #1;
      rst_n = 1'b1;
      push_pkt(0, 1); push_pkt(2, 1); push_pkt(3, 1);
      run_until_idle("postrst", 100);
      exp_grants.push_back(0); exp_grants.push_back(1);
      exp_grants.push_back(2); exp_grants.push_back(3);
      exp_bursts.push_back(1); exp_bursts.push_back(3);
      exp_bursts.push_back(1); exp_bursts.push_back(1);
      compare_logs("postrst");

      // random traffic, link flaps and valid gaps
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0 && pq[i].size() < 30)
               push_pkt(i, int'($urandom_range(1, 12)));
            en[i] = ($urandom_range(0, 3) != 0);
         end
         link_drv = ($urandom_range(0, 19) != 0);
         cycle();
      end
      for (int i = 0; i < N; i++) en[i] = 1'b1;
      link_drv = 1'b1;
      run_until_idle("rand", 2000);
      clear_logs();

      $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
      $finish;
   end

endmodule
